i2c_target_sim: RTL and testbench

I2C_TARGET_SIM -- requirements
Module: i2c_target_sim

---
 rtl/i2c_target_sim.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_target_sim.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_sim.sv
// I2C target exposing a small byte register file: write a pointer byte, then write or read
// data bytes with auto-increment. SDA is open-drain via sda_oe_o; bus inputs are synchronized.
module i2c_target_sim #(
    parameter logic [6:0]  TargetAddr = 7'h50,
    parameter int unsigned MemDepth   = 16,
    localparam int unsigned AddrW     = $clog2(MemDepth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe_o,
    output logic             busy_o,
    output logic             wr_valid_o,
    output logic [AddrW-1:0] wr_addr_o,
    output logic [7:0]       wr_data_o
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck, StRdata, StRdataAck
    } state_e;

    logic scl_s1_q, scl_s2_q, scl_dly_q;
    logic sda_s1_q, sda_s2_q, sda_dly_q;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       sr_q, sr_d;
    logic [AddrW-1:0] ptr_q, ptr_d;
    logic             ack_q, ack_d;
    logic             rw_q, rw_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             wr_valid_q, wr_valid_d;
    logic [AddrW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic [7:0]       mem_q [MemDepth];

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in, rd_byte;

    assign scl_rise  = scl_s2_q & ~scl_dly_q;
    assign scl_fall  = ~scl_s2_q & scl_dly_q;
    assign start_det = ~sda_s2_q & sda_dly_q & scl_s2_q;
    assign stop_det  = sda_s2_q & ~sda_dly_q & scl_s2_q;
    assign byte_in   = {sr_q[6:0], sda_s2_q};
    assign rd_byte   = mem_q[ptr_q];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        ptr_d      = ptr_q;
        ack_d      = ack_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (stop_det) begin
            state_d  = StIdle;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            // Also a repeated START; any partial byte is simply dropped.
            state_d  = StAddr;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr, StPtr, StWdata: begin
                    if (scl_rise) begin
                        sr_d  = byte_in;
                        cnt_d = cnt_q + 4'd1;
                        ack_d = 1'b0;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (state_q == StAddr) begin
                                if (byte_in[7:1] == TargetAddr) begin
                                    state_d = StAddrAck;
                                    busy_d  = 1'b1;
                                    rw_d    = byte_in[0];
                                end else begin
                                    state_d = StIdle;
                                end
                            end else if (state_q == StPtr) begin
                                ptr_d   = byte_in[AddrW-1:0];
                                state_d = StPtrAck;
                            end else begin
                                wr_valid_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = byte_in;
                                ptr_d      = ptr_q + AddrW'(1);
                                state_d    = StWdataAck;
                            end
                        end
                    end
                end
                StAddrAck, StPtrAck, StWdataAck: begin
                    // First SCL fall starts driving ACK, the second one ends it.
                    if (scl_fall) begin
                        if (!ack_q) begin
                            ack_d    = 1'b1;
                            sda_oe_d = 1'b1;
                        end else begin
                            ack_d    = 1'b0;
                            cnt_d    = 4'd0;
                            sda_oe_d = 1'b0;
                            if (state_q == StAddrAck && rw_q) begin
                                state_d  = StRdata;
                                sr_d     = rd_byte;
                                sda_oe_d = ~rd_byte[7];
                            end else if (state_q == StAddrAck) begin
                                state_d = StPtr;
                            end else begin
                                state_d = StWdata;
                            end
                        end
                    end
                end
                StRdata: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_d  = StRdataAck;
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            ack_d    = 1'b0;
                        end else begin
                            sr_d     = {sr_q[6:0], 1'b0};
                            sda_oe_d = ~sr_q[6];
                        end
                    end
                end
                StRdataAck: begin
                    if (scl_rise) begin
                        if (!sda_s2_q) begin
                            ptr_d = ptr_q + AddrW'(1);
                            ack_d = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else if (scl_fall && ack_q) begin
                        state_d  = StRdata;
                        ack_d    = 1'b0;
                        cnt_d    = 4'd0;
                        sr_d     = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_dly_q  <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_dly_q  <= 1'b1;
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            sr_q       <= 8'h00;
            ptr_q      <= '0;
            ack_q      <= 1'b0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            mem_q      <= '{default: 8'h00};
        end else begin
            scl_s1_q   <= scl_i;
            scl_s2_q   <= scl_s1_q;
            scl_dly_q  <= scl_s2_q;
            sda_s1_q   <= sda_i;
            sda_s2_q   <= sda_s1_q;
            sda_dly_q  <= sda_s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            if (wr_valid_d) begin
                mem_q[wr_addr_d] <= wr_data_d;
            end
        end
    end

    assign sda_oe_o   = sda_oe_q;
    assign busy_o     = busy_q;
    assign wr_valid_o = wr_valid_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_i2c_target_sim.sv
// Directed bench for i2c_target_sim: a bit-banged I2C master drives the bus and checks
// ACKs, read data, write strobes and busy against hand-computed values.
module tb_i2c_target_sim;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe, busy, wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_sim #(
        .TargetAddr(7'h50),
        .MemDepth  (16)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .scl_i     (scl_m),
        .sda_i     (sda_bus),
        .sda_oe_o  (sda_oe),
        .busy_o    (busy),
        .wr_valid_o(wr_valid),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data)
    );

    // Bus monitors: write strobes, SDA-enable cycles, and SDA-enable changes while SCL high.
    int   wr_a[$];
    int   wr_d[$];
    int   oe_hi = 0;
    int   oe_viol = 0;
    logic oe_prev = 1'b0;
    logic mon_en = 1'b1;

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_a.push_back(int'(wr_addr));
            wr_d.push_back(int'(wr_data));
        end
        if (sda_oe) oe_hi++;
        if (mon_en && !rst && scl_m && (sda_oe !== oe_prev)) oe_viol++;
        oe_prev = sda_oe;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; hold(Q);
        scl_m = 1'b1; hold(Q);
        sda_m = 1'b0; hold(Q);
        scl_m = 1'b0; hold(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; hold(Q);
        scl_m = 1'b1; hold(Q);
        sda_m = 1'b1; hold(Q);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b;    hold(Q);
        scl_m = 1'b1; hold(Q);
        s = sda_bus;  hold(Q);
        scl_m = 1'b0; hold(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(~master_ack, s);
    endtask

    task automatic send(input string tag, input logic [7:0] b, input logic exp_ack);
        logic a;
        write_byte(b, a);
        check_eq(tag, int'(a), int'(exp_ack));
    endtask

    task automatic recv(input string tag, input logic master_ack, input logic [7:0] exp);
        logic [7:0] d;
        read_byte(master_ack, d);
        check_eq(tag, int'(d), int'(exp));
    endtask

    initial begin
        int base;
        logic s;

        hold(3);
        check_eq("rst_sda_oe", int'(sda_oe), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_wr_valid", int'(wr_valid), 0);
        check_eq("rst_wr_addr", int'(wr_addr), 0);
        check_eq("rst_wr_data", int'(wr_data), 0);
        rst = 1'b0;
        hold(Q);

        // Write 0x5A, 0xC3 starting at register 3.
        i2c_start();
        send("wr_addr_ack", 8'hA0, 1'b1);
        check_eq("wr_busy_set", int'(busy), 1);
        send("wr_ptr_ack", 8'h03, 1'b1);
        send("wr_d0_ack", 8'h5A, 1'b1);
        send("wr_d1_ack", 8'hC3, 1'b1);
        check_eq("wr_busy_before_stop", int'(busy), 1);
        i2c_stop();
        check_eq("wr_busy_after_stop", int'(busy), 0);
        check_eq("wr_log_size", wr_a.size(), 2);
        check_eq("wr_log0_addr", (wr_a.size() > 0) ? wr_a[0] : -1, 3);
        check_eq("wr_log0_data", (wr_d.size() > 0) ? wr_d[0] : -1, 8'h5A);
        check_eq("wr_log1_addr", (wr_a.size() > 1) ? wr_a[1] : -1, 4);
        check_eq("wr_log1_data", (wr_d.size() > 1) ? wr_d[1] : -1, 8'hC3);

        // Pointer-only write, repeated START, read two bytes.
        i2c_start();
        send("rd_addr_ack", 8'hA0, 1'b1);
        send("rd_ptr_ack", 8'h03, 1'b1);
        i2c_start();
        send("rd_raddr_ack", 8'hA1, 1'b1);
        recv("rd_byte0", 1'b1, 8'h5A);
        recv("rd_byte1", 1'b0, 8'hC3);
        check_eq("rd_busy_after_nack", int'(busy), 1);
        i2c_stop();
        check_eq("rd_busy_after_stop", int'(busy), 0);

        // Pointer wrap on write and on read.
        base = wr_a.size();
        i2c_start();
        send("wrap_addr_ack", 8'hA0, 1'b1);
        send("wrap_ptr_ack", 8'h0F, 1'b1);
        send("wrap_d0_ack", 8'h11, 1'b1);
        send("wrap_d1_ack", 8'h22, 1'b1);
        i2c_stop();
        check_eq("wrap_log_size", wr_a.size() - base, 2);
        check_eq("wrap_log0_addr", (wr_a.size() > base) ? wr_a[base] : -1, 15);
        check_eq("wrap_log1_addr", (wr_a.size() > base + 1) ? wr_a[base + 1] : -1, 0);
        i2c_start();
        send("wrap_rd_addr_ack", 8'hA0, 1'b1);
        send("wrap_rd_ptr_ack", 8'h0F, 1'b1);
        i2c_start();
        send("wrap_rd_raddr_ack", 8'hA1, 1'b1);
        recv("wrap_rd_mem15", 1'b1, 8'h11);
        recv("wrap_rd_mem0", 1'b0, 8'h22);
        i2c_stop();

        // Address mismatch: no ACK, SDA never driven, then a normal transaction.
        base = oe_hi;
        i2c_start();
        send("mis_addr_nack", 8'hA2, 1'b0);
        send("mis_byte2_nack", 8'h55, 1'b0);
        check_eq("mis_oe_cycles", oe_hi - base, 0);
        check_eq("mis_busy", int'(busy), 0);
        i2c_stop();
        base = wr_a.size();
        i2c_start();
        send("mis_next_addr_ack", 8'hA0, 1'b1);
        send("mis_next_ptr_ack", 8'h05, 1'b1);
        send("mis_next_d_ack", 8'h77, 1'b1);
        i2c_stop();
        check_eq("mis_next_log_size", wr_a.size() - base, 1);
        check_eq("mis_next_log_data", (wr_d.size() > base) ? wr_d[base] : -1, 8'h77);

        // STOP after 4 data bits: nothing written, target idle.
        base = wr_a.size();
        i2c_start();
        send("abort_addr_ack", 8'hA0, 1'b1);
        send("abort_ptr_ack", 8'h05, 1'b1);
        for (int i = 0; i < 4; i++) clk_bit(i[0], s);
        i2c_stop();
        check_eq("abort_no_write", wr_a.size() - base, 0);
        check_eq("abort_busy", int'(busy), 0);
        send("abort_idle_ignores", 8'hA0, 1'b0);
        i2c_start();
        send("abort_rd_addr_ack", 8'hA0, 1'b1);
        send("abort_rd_ptr_ack", 8'h05, 1'b1);
        i2c_start();
        send("abort_rd_raddr_ack", 8'hA1, 1'b1);
        recv("abort_mem_unchanged", 1'b0, 8'h77);
        i2c_stop();

        // Reset while presenting a 0 bit of mem[5] = 0x77.
        i2c_start();
        send("rstrd_addr_ack", 8'hA1, 1'b1);
        check_eq("rstrd_driving", int'(sda_oe), 1);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rstrd_release", int'(sda_oe), 0);
        check_eq("rstrd_busy", int'(busy), 0);
        hold(4);
        scl_m = 1'b1;
        sda_m = 1'b1;
        hold(4);
        rst = 1'b0;
        hold(Q);
        mon_en = 1'b1;
        i2c_start();
        send("rstrd_rd_addr_ack", 8'hA0, 1'b1);
        send("rstrd_rd_ptr_ack", 8'h05, 1'b1);
        i2c_start();
        send("rstrd_rd_raddr_ack", 8'hA1, 1'b1);
        recv("rstrd_mem_cleared", 1'b0, 8'h00);
        i2c_stop();

        check_eq("oe_change_while_scl_high", oe_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
